// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type, limits and validity helper
package bcd_pkg;
  typedef logic [3:0] bcd_t;
  localparam bcd_t BCD_MAX = 4'd9;
  localparam bcd_t BCD_MIN = 4'd0;
  function automatic logic is_bcd(input logic [3:0] n);
    return n <= BCD_MAX;
  endfunction
endpackage

// File: rtl/bcd_digit_cell.sv
// bcd_digit_cell: one BCD digit register with load/clear/inc/dec, load > clear > inc > dec
import bcd_pkg::*;
module bcd_digit_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic clr,
  input  logic inc,
  input  logic dec,
  input  bcd_t d,
  output bcd_t digit,
  output logic is_max,
  output logic is_min
);
  assign is_max = digit == BCD_MAX;
  assign is_min = digit == BCD_MIN;
  // digit register; inc/dec wrap inside 0..9 so the cell never holds a non-BCD value
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) digit <= BCD_MIN;
    else if (load) digit <= d;
    else if (clr) digit <= BCD_MIN;
    else if (inc) digit <= is_max ? BCD_MIN : digit + 4'd1;
    else if (dec) digit <= is_min ? BCD_MAX : digit - 4'd1;
endmodule

// File: rtl/bcd_updown_counter_n.sv
// bcd_updown_counter_n: N-digit BCD up/down counter with load, clear, wrap/saturate and carry pulse
import bcd_pkg::*;
module bcd_updown_counter_n #(
  parameter int DIGITS = 4,
  parameter bit SAT    = 1'b0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN,
  input  logic              UP,
  input  logic              CLR,
  input  logic              LOAD,
  input  logic [4*DIGITS-1:0] D,
  output logic [4*DIGITS-1:0] Q,
  output logic              TC,
  output logic              CO,
  output logic              LD_ERR
);
  bcd_t d_fix [DIGITS];
  logic [DIGITS-1:0] is_max, is_min, inc, dec;
  logic [DIGITS:0] max_run, min_run;
  logic bad, hi_max, hi_min, hold, step, reach, co_next;
  // carry/borrow chain, load sanitising, terminal and saturation detection
  always_comb begin
    max_run[0] = 1'b1;
    min_run[0] = 1'b1;
    bad = 1'b0;
    hi_max = 1'b1;
    hi_min = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      max_run[i+1] = max_run[i] & is_max[i];
      min_run[i+1] = min_run[i] & is_min[i];
      bad = bad | !is_bcd(D[4*i+:4]);
      d_fix[i] = is_bcd(D[4*i+:4]) ? D[4*i+:4] : BCD_MIN;
      if (i > 0) begin
        hi_max = hi_max & is_max[i];
        hi_min = hi_min & is_min[i];
      end
    end
    TC = UP ? max_run[DIGITS] : min_run[DIGITS];
    hold = SAT && TC;
    step = EN & ~LOAD & ~CLR & ~hold;
    for (int i = 0; i < DIGITS; i++) begin
      inc[i] = step & UP & max_run[i];
      dec[i] = step & ~UP & min_run[i];
    end
    reach = UP ? hi_max && Q[3:0] == 4'd8 : hi_min && Q[3:0] == 4'd1;
    co_next = step & (SAT ? reach : TC);
  end
  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      bcd_digit_cell u_cell (
        .clk(CLK), .rst_n(RST_N), .load(LOAD), .clr(CLR), .inc(inc[g]), .dec(dec[g]),
        .d(d_fix[g]), .digit(Q[4*g+:4]), .is_max(is_max[g]), .is_min(is_min[g])
      );
    end
  endgenerate
  // one-cycle carry and illegal-load pulses
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      CO <= 1'b0;
      LD_ERR <= 1'b0;
    end else begin
      CO <= co_next;
      LD_ERR <= LOAD & bad;
    end
endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// tb_bcd_updown_counter_n: four configurations checked against a decimal-integer reference model
module tb_bcd_updown_counter_n;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, up = 1'b0, clr = 1'b0, load = 1'b0;
  logic [31:0] d = 32'h0;
  logic [15:0] q_w, q_s;
  logic [3:0] q_1;
  logic [31:0] q_8;
  wire [3:0] tc, co, le;
  int n_tests = 0, n_fail = 0;
  int nd [4] = '{4, 4, 1, 8};
  bit sat [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  longint val [4];
  bit mco [4], mle [4];
  always #5 clk = ~clk;
  bcd_updown_counter_n #(.DIGITS(4), .SAT(1'b0)) u_w (.CLK(clk), .RST_N(rst_n), .EN(en), .UP(up), .CLR(clr),
    .LOAD(load), .D(d[15:0]), .Q(q_w), .TC(tc[0]), .CO(co[0]), .LD_ERR(le[0]));
  bcd_updown_counter_n #(.DIGITS(4), .SAT(1'b1)) u_s (.CLK(clk), .RST_N(rst_n), .EN(en), .UP(up), .CLR(clr),
    .LOAD(load), .D(d[15:0]), .Q(q_s), .TC(tc[1]), .CO(co[1]), .LD_ERR(le[1]));
  bcd_updown_counter_n #(.DIGITS(1), .SAT(1'b0)) u_1 (.CLK(clk), .RST_N(rst_n), .EN(en), .UP(up), .CLR(clr),
    .LOAD(load), .D(d[3:0]), .Q(q_1), .TC(tc[2]), .CO(co[2]), .LD_ERR(le[2]));
  bcd_updown_counter_n #(.DIGITS(8), .SAT(1'b0)) u_8 (.CLK(clk), .RST_N(rst_n), .EN(en), .UP(up), .CLR(clr),
    .LOAD(load), .D(d), .Q(q_8), .TC(tc[3]), .CO(co[3]), .LD_ERR(le[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic longint lim(input int n);
    longint r = 1;
    repeat (n) r = r * 10;
    return r - 1;
  endfunction

  function automatic logic [31:0] to_bcd(input longint v, input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) begin
      r[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] q_of(input int k);
    return k == 0 ? {16'h0, q_w} : k == 1 ? {16'h0, q_s} : k == 2 ? {28'h0, q_1} : q_8;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      val[k] = 0;
      mco[k] = 0;
      mle[k] = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 4; k++) begin
      longint m, p;
      logic [3:0] nib;
      m = lim(nd[k]);
      mco[k] = 0;
      mle[k] = 0;
      if (load) begin
        p = 1;
        val[k] = 0;
        for (int i = 0; i < nd[k]; i++) begin
          nib = d[4*i+:4];
          if (nib > 9) mle[k] = 1;
          else val[k] += longint'(nib) * p;
          p = p * 10;
        end
      end else if (clr) val[k] = 0;
      else if (en && up) begin
        if (val[k] == m) begin
          if (!sat[k]) begin val[k] = 0; mco[k] = 1; end
        end else begin
          val[k]++;
          mco[k] = sat[k] && val[k] == m;
        end
      end else if (en) begin
        if (val[k] == 0) begin
          if (!sat[k]) begin val[k] = m; mco[k] = 1; end
        end else begin
          val[k]--;
          mco[k] = sat[k] && val[k] == 0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s.q%0d", tag, k), q_of(k), to_bcd(val[k], nd[k]));
      check($sformatf("%s.tc%0d", tag, k), 32'(tc[k]), 32'(up ? val[k] == lim(nd[k]) : val[k] == 0));
      check($sformatf("%s.co%0d", tag, k), 32'(co[k]), 32'(mco[k]));
      check($sformatf("%s.le%0d", tag, k), 32'(le[k]), 32'(mle[k]));
    end
  endtask

  task automatic drive(input logic l, input logic c, input logic e, input logic u, input logic [31:0] dv);
    load = l;
    clr = c;
    en = e;
    up = u;
    d = dv;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1 check_all(tag);
  endtask

  initial begin
    int cnt;
    logic up_r;
    model_reset();
    #12 check_all("rst");
    rst_n = 1'b1;
    drive(1, 0, 0, 1, 32'h0537);
    tick("ld537");
    drive(0, 0, 0, 1, 32'h0);
    #3 rst_n = 1'b0;
    model_reset();
    #1 check_all("arst");
    check("arst_q", {16'h0, q_w}, 32'h0);
    rst_n = 1'b1;
    drive(1, 0, 0, 1, 32'h9998);
    tick("ld9998");
    drive(0, 0, 1, 1, 32'h0);
    tick("upw1");
    check("upw1_q", {16'h0, q_w}, 32'h9999);
    tick("upw2");
    check("upw2_q", {16'h0, q_w}, 32'h0000);
    check("upw2_co", 32'(co[0]), 32'h1);
    tick("upw3");
    check("upw3_q", {16'h0, q_w}, 32'h0001);
    check("upw3_co", 32'(co[0]), 32'h0);
    drive(1, 0, 0, 0, 32'h1000);
    tick("ld1000");
    drive(0, 0, 1, 0, 32'h0);
    tick("dn1");
    check("dn1_q", {16'h0, q_w}, 32'h0999);
    check("dn1_tc", 32'(tc[0]), 32'h0);
    tick("dn2");
    check("dn2_q", {16'h0, q_w}, 32'h0998);
    check("dn2_tc", 32'(tc[0]), 32'h0);
    drive(1, 0, 0, 0, 32'h0001);
    tick("ld0001");
    drive(0, 0, 1, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick("sat");
      check($sformatf("sat%0d_q", i), {16'h0, q_s}, 32'h0);
      check($sformatf("sat%0d_co", i), 32'(co[1]), 32'(i == 0));
      check($sformatf("sat%0d_tc", i), 32'(tc[1]), 32'h1);
    end
    drive(0, 0, 1, 1, 32'h0);
    tick("sat_rev");
    check("sat_rev_q", {16'h0, q_s}, 32'h0001);
    drive(1, 1, 1, 1, 32'h12A4);
    tick("prio");
    check("prio_q", {16'h0, q_w}, 32'h1204);
    check("prio_le", 32'(le[0]), 32'h1);
    drive(0, 1, 0, 1, 32'h0);
    tick("clr");
    check("clr_q", {16'h0, q_w}, 32'h0);
    check("clr_le", 32'(le[0]), 32'h0);
    drive(0, 0, 1, 1, 32'h0);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick("sw1");
      cnt += int'(co[2]);
    end
    check("sw1_co_count", 32'(cnt), 32'd3);
    drive(1, 0, 0, 1, 32'h99999995);
    tick("ld8");
    drive(0, 0, 1, 1, 32'h0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick("sw8");
      cnt += int'(co[3]);
    end
    check("sw8_co_count", 32'(cnt), 32'd1);
    check("sw8_q", q_8, 32'h00000005);
    up_r = 1'b1;
    for (int n = 0; n < 600; n++) begin
      int r;
      logic [31:0] dv;
      r = int'($urandom_range(0, 63));
      dv = (r % 3 == 0) ? 32'h99999998 : (r % 3 == 1) ? 32'h00000001 : $urandom;
      if (n % 20 == 0) up_r = 1'($urandom_range(0, 1));
      drive(r < 4, r >= 4 && r < 6, r >= 12, up_r, dv);
      tick("rnd");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
